escalonador_imagens: RTL and testbench

Frame-synchronous scheduler that drives the 4-bit `estado` image selector consumed by `controlador_imagens`. Inputs are debounced button pulses from `controlador_botao` and an end-of-frame pulse derived from `controlador_display`. It latches button requests and holds each action image for a fixed number of whole frames. When idle it alternates a blink image. `estado` changes only at frame boundaries, so no frame is ever torn.

---
 rtl/pkg_tamagotchi.sv | 27 ++
 rtl/contador_quadros.sv | 39 +++
 rtl/escalonador_imagens.sv | 113 +++++++++++
 tb/tb_escalonador_imagens.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_tamagotchi.sv
// ============================================================================
// Module      : pkg_tamagotchi
// Description : Shared definitions for the image scheduler: image selector
//               codes understood by controlador_imagens and the scheduler
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_tamagotchi;

  // Image selector codes
  localparam logic [3:0] ESTADO_NORMAL = 4'b0000;
  localparam logic [3:0] ESTADO_ACAO1  = 4'b0001;
  localparam logic [3:0] ESTADO_ACAO2  = 4'b0010;
  localparam logic [3:0] ESTADO_PISCA  = 4'b0011;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACAO1 = 2'd1,
    ACAO2 = 2'd2
  } fsm_t;

endpackage

`default_nettype wire

// File: rtl/contador_quadros.sv
// ============================================================================
// Module      : contador_quadros
// Description : Frame counter. Counts enable pulses, synchronous clear has
//               priority over counting, tc flags count == limit.
// Ports       : clk, reset  - clock / synchronous active-high reset
//               clear       - force count to zero this cycle
//               enable      - count one frame
//               limit       - terminal-count value
//               tc          - high while count equals limit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_quadros #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

`default_nettype wire

// File: rtl/escalonador_imagens.sv
// ============================================================================
// Module      : escalonador_imagens
// Description : Frame-synchronous image scheduler. Latches button requests,
//               holds each action image for HOLD_FRAMES whole frames and
//               blinks the idle image every BLINK_FRAMES frames. The selector
//               only changes on frame_done so no frame is ever torn.
// Ports       : clk, reset  - clock / synchronous active-high reset
//               b1_pulse    - request action 1 (priority)
//               b2_pulse    - request action 2
//               frame_done  - end-of-frame pulse, the only decision point
//               estado      - registered image selector
//               ocupado     - high while an action image is held
//               troca       - one-cycle pulse when estado changes value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module escalonador_imagens
  import pkg_tamagotchi::*;
#(
  parameter int HOLD_FRAMES  = 60,
  parameter int BLINK_FRAMES = 120,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b1_pulse,
  input  logic       b2_pulse,
  input  logic       frame_done,
  output logic [3:0] estado,
  output logic       ocupado,
  output logic       troca
);

  fsm_t             state, state_n;
  logic [3:0]       estado_n;
  logic             p1, p2;
  logic             req1, req2;
  logic             serve1, serve2;
  logic             cnt_clear;
  logic             tc;
  logic [CNT_W-1:0] limit;

  // One counter serves both timings: the limit follows the current state.
  assign limit = (state == IDLE) ? CNT_W'(BLINK_FRAMES - 1)
                                 : CNT_W'(HOLD_FRAMES - 1);

  contador_quadros #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (frame_done),
    .limit  (limit),
    .tc     (tc)
  );

  // A pulse arriving together with frame_done counts for this decision.
  assign req1 = p1 | b1_pulse;
  assign req2 = p2 | b2_pulse;

  always_comb begin
    state_n   = state;
    estado_n  = estado;
    cnt_clear = 1'b0;
    serve1    = 1'b0;
    serve2    = 1'b0;
    // Idle decides on every frame; an action only once its hold expires.
    if (frame_done && (state == IDLE || tc)) begin
      if (req1) begin
        state_n   = ACAO1;
        estado_n  = ESTADO_ACAO1;
        cnt_clear = 1'b1;
        serve1    = 1'b1;
      end else if (req2) begin
        state_n   = ACAO2;
        estado_n  = ESTADO_ACAO2;
        cnt_clear = 1'b1;
        serve2    = 1'b1;
      end else if (state != IDLE) begin
        state_n   = IDLE;
        estado_n  = ESTADO_NORMAL;
        cnt_clear = 1'b1;
      end else if (tc) begin
        cnt_clear = 1'b1;
        estado_n  = (estado == ESTADO_PISCA) ? ESTADO_NORMAL : ESTADO_PISCA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      estado  <= ESTADO_NORMAL;
      ocupado <= 1'b0;
      troca   <= 1'b0;
      p1      <= 1'b0;
      p2      <= 1'b0;
    end else begin
      state   <= state_n;
      estado  <= estado_n;
      ocupado <= (state_n != IDLE);
      // Re-entering the same action leaves estado unchanged, so no pulse.
      troca   <= (estado_n != estado);
      p1      <= req1 & ~serve1;
      p2      <= req2 & ~serve2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_escalonador_imagens.sv
// ============================================================================
// Module      : tb_escalonador_imagens
// Description : Scoreboard bench for escalonador_imagens with HOLD_FRAMES=3,
//               BLINK_FRAMES=4 and frame_done every 10 cycles. Each expected
//               estado change is queued with the frame number that causes it;
//               a monitor pops an entry on every troca pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_escalonador_imagens;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b1_pulse = 1'b0;
  logic       b2_pulse = 1'b0;
  logic       frame_done = 1'b0;
  logic [3:0] estado;
  logic       ocupado;
  logic       troca;

  escalonador_imagens #(
    .HOLD_FRAMES  (3),
    .BLINK_FRAMES (4),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .b1_pulse   (b1_pulse),
    .b2_pulse   (b2_pulse),
    .frame_done (frame_done),
    .estado     (estado),
    .ocupado    (ocupado),
    .troca      (troca)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] est;
    logic       ocp;
    int         frame;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         tests = 0;
  int         fails = 0;
  int         fcount = 0;
  bit         mon_en = 1'b0;
  bit         rst_jump = 1'b0;
  logic [3:0] prev_est;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] est, input logic ocp, input int frame);
    exp_t x;
    x.est = est;
    x.ocp = ocp;
    x.frame = frame;
    sb.push_back(x);
  endtask

  // One frame period: optional button pulses mid-frame (m1/m2) and/or in
  // the frame_done cycle itself (f1/f2).
  task automatic frame(input bit m1, input bit m2, input bit f1, input bit f2);
    cycles(4);
    b1_pulse = m1;
    b2_pulse = m2;
    cycles(1);
    b1_pulse = 1'b0;
    b2_pulse = 1'b0;
    cycles(4);
    frame_done = 1'b1;
    b1_pulse = f1;
    b2_pulse = f2;
    fcount++;
    cycles(1);
    frame_done = 1'b0;
    b1_pulse = 1'b0;
    b2_pulse = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (frame %0d)", name, act, req, fcount);
    end
  endtask

  // Monitor: every troca must match the head of the scoreboard, and estado
  // must never change without troca.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (rst_jump) begin
        rst_jump = 1'b0;
        prev_est = estado;
      end else begin
        if (troca) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_troca: got estado=%b at frame %0d required no change",
                     estado, fcount);
          end else begin
            e = sb.pop_front();
            check("estado", 32'(estado), 32'(e.est));
            check("ocupado", 32'(ocupado), 32'(e.ocp));
            check("change_frame", 32'(fcount), 32'(e.frame));
          end
        end else if (estado !== prev_est) begin
          tests++;
          fails++;
          $display("FAIL silent_change: got estado %b->%b without troca required troca=1",
                   prev_est, estado);
        end
        prev_est = estado;
      end
    end
  end

  initial begin
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_estado", 32'(estado), 32'h0);
    check("reset_ocupado", 32'(ocupado), 32'h0);
    check("reset_troca", 32'(troca), 32'h0);
    prev_est = estado;
    mon_en = 1'b1;

    // Idle blink: toggles on the 4th and 8th frames
    push(4'b0011, 1'b0, 4);
    push(4'b0000, 1'b0, 8);
    repeat (8) frame(0, 0, 0, 0);

    // b1 mid-frame: action 1 held for 3 frames
    push(4'b0001, 1'b1, 9);
    push(4'b0000, 1'b0, 12);
    frame(1, 0, 0, 0);
    repeat (3) frame(0, 0, 0, 0);

    // b1 and b2 together: action 1 first, then action 2
    push(4'b0001, 1'b1, 13);
    push(4'b0010, 1'b1, 16);
    push(4'b0000, 1'b0, 19);
    frame(1, 1, 0, 0);
    repeat (6) frame(0, 0, 0, 0);

    // b2 in the frame_done cycle
    push(4'b0010, 1'b1, 20);
    push(4'b0000, 1'b0, 23);
    frame(0, 0, 0, 1);
    repeat (3) frame(0, 0, 0, 0);

    // Second b1 during action 1: silent restart, 6 frames total
    push(4'b0001, 1'b1, 24);
    push(4'b0000, 1'b0, 30);
    frame(1, 0, 0, 0);
    frame(0, 0, 0, 0);
    frame(1, 0, 0, 0);
    repeat (4) frame(0, 0, 0, 0);

    // Reset during action 2 with b1 pending: everything dropped
    push(4'b0010, 1'b1, 31);
    frame(0, 1, 0, 0);
    cycles(3);
    b1_pulse = 1'b1;
    cycles(1);
    b1_pulse = 1'b0;
    cycles(1);
    rst_jump = 1'b1;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_estado", 32'(estado), 32'h0);
    check("post_reset_ocupado", 32'(ocupado), 32'h0);
    cycles(1);
    // Counter restarted from zero: next blink on the 4th frame after reset
    push(4'b0011, 1'b0, 35);
    repeat (4) frame(0, 0, 0, 0);
    cycles(3);
    check("post_reset_ocupado_end", 32'(ocupado), 32'h0);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
